// File: rtl/decoder_select_sequencer_pkg.sv
// Shared definitions for the decoder self-test sequencer: mode codes, FSM states and
// the one-hot reference used to judge each decoder word.
package decoder_select_sequencer_pkg;

  localparam logic [1:0] ModeUp     = 2'b00;
  localparam logic [1:0] ModeDown   = 2'b01;
  localparam logic [1:0] ModeSingle = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  function automatic logic [7:0] onehot8(input logic [2:0] code);
    return 8'b1 << code;
  endfunction

endpackage

// File: rtl/decoder_select_sequencer_counter.sv
// 3-bit mod-8 up/down counter with synchronous load and enable; drives the select code.
module updown_counter3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       en_i,
  input  logic       up_i,
  output logic [2:0] q_o
);

  logic [2:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = up_i ? q_q + 3'd1 : q_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 3'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/decoder_select_sequencer.sv
// Sweeps or presents select codes to a 3-to-8 decoder and flags any output word that
// is not the expected one-hot value; the first failing code is kept in err_code.
module decoder_select_sequencer
  import decoder_select_sequencer_pkg::*;
#(
  parameter int unsigned STEP_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [2:0] load_val,
  input  logic [7:0] dec_y,
  output logic [2:0] sel,
  output logic       busy,
  output logic       sweep_done,
  output logic       err,
  output logic [2:0] err_code
);

  localparam logic [3:0] PrescLast = 4'(STEP_DIV - 1);

  state_e     state_q, state_d;
  logic [3:0] presc_q, presc_d;
  logic [3:0] count_q, count_d;
  logic [1:0] mode_q, mode_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [2:0] err_code_q, err_code_d;

  logic       cnt_load, cnt_en, cnt_up;
  logic [2:0] sel_q;
  logic [3:0] last_count;

  updown_counter3 u_sel_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (load_val),
    .en_i       (cnt_en),
    .up_i       (cnt_up),
    .q_o        (sel_q)
  );

  // Reserved mode 11 behaves as an up-sweep.
  assign cnt_up     = (mode_q != ModeDown);
  assign last_count = (mode_q == ModeSingle) ? 4'd0 : 4'd7;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    count_d    = count_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_load   = 1'b1;
          mode_d     = mode;
          err_d      = 1'b0;
          err_code_d = 3'd0;
          presc_d    = 4'd0;
          count_d    = 4'd0;
          busy_d     = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (presc_q == PrescLast) begin
          presc_d = 4'd0;
          count_d = count_q + 4'd1;
          if (dec_y != onehot8(sel_q) && !err_q) begin
            err_d      = 1'b1;
            err_code_d = sel_q;
          end
          if (count_q == last_count) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_en = 1'b1;
          end
        end else begin
          presc_d = presc_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      presc_q    <= 4'd0;
      count_q    <= 4'd0;
      mode_q     <= ModeUp;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      count_q    <= count_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_decoder_select_sequencer.sv
// Directed bench: two sequencers (STEP_DIV 1 and 3), each around a behavioural decoder
// whose outputs can be stuck low through a fault mask.
module tb_decoder_select_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3, stop;
  logic [1:0] mode;
  logic [2:0] load_val;
  logic [7:0] fault_mask;

  logic [7:0] dec_y1, dec_y3;
  logic [2:0] sel1, sel3, err_code1, err_code3;
  logic       busy1, busy3, done1, done3, err1, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dec_y1 = (8'b1 << sel1) & ~fault_mask;
  assign dec_y3 = (8'b1 << sel3) & ~fault_mask;

  decoder_select_sequencer #(.STEP_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop), .mode(mode), .load_val(load_val),
    .dec_y(dec_y1), .sel(sel1), .busy(busy1), .sweep_done(done1), .err(err1),
    .err_code(err_code1)
  );

  decoder_select_sequencer #(.STEP_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stop(stop), .mode(mode), .load_val(load_val),
    .dec_y(dec_y3), .sel(sel3), .busy(busy3), .sweep_done(done3), .err(err3),
    .err_code(err_code3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Packs {sel, busy, done, err, err_code} of dut1 for compact comparisons.
  function automatic logic [8:0] st1();
    return {sel1, busy1, done1, err1, err_code1};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start1 = 0; start3 = 0; stop = 0; mode = 2'b00; load_val = 3'd0;
    fault_mask = 8'h00;
    #12;
    checks++;
    if (st1() !== 9'b000_0_0_0_000) begin
      $display("FAIL reset_dut1: got %b want 000000000", st1()); errors++;
    end
    checks++;
    if ({sel3, busy3, done3, err3, err_code3} !== 9'd0) begin
      $display("FAIL reset_dut3: got %b want 0", {sel3, busy3, done3, err3, err_code3});
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_up_sweep();
    mode = 2'b00; load_val = 3'd0; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sel1 !== 3'(k) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        $display("FAIL up_step%0d: sel=%0d busy=%b done=%b want sel=%0d busy=1 done=0",
                 k, sel1, busy1, done1, k);
        errors++;
      end
      if (k == 2) start1 = 1'b1;  // start while busy must be ignored
      if (k == 3) start1 = 1'b0;
      cyc();
    end
    checks++;
    if (st1() !== {3'd7, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      $display("FAIL up_end: got %b want 111_0_1_0_000", st1()); errors++;
    end
    cyc();
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      $display("FAIL up_done_width: done=%b busy=%b want 0 0", done1, busy1); errors++;
    end
  endtask

  task automatic test_down_sweep();
    logic [2:0] exp_seq [8] = '{3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    mode = 2'b01; load_val = 3'd2; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    mode = 2'b00; load_val = 3'd5;  // mid-run changes must have no effect
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sel1 !== exp_seq[k] || busy1 !== 1'b1) begin
        $display("FAIL down_step%0d: sel=%0d busy=%b want sel=%0d busy=1",
                 k, sel1, busy1, exp_seq[k]);
        errors++;
      end
      cyc();
    end
    checks++;
    if (st1() !== {3'd3, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      $display("FAIL down_end: got %b want 011_0_1_0_000", st1()); errors++;
    end
    cyc();
  endtask

  task automatic test_fault();
    mode = 2'b00; load_val = 3'd0; fault_mask = 8'h60; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    repeat (5) cyc();
    checks++;
    if (err1 !== 1'b0 || sel1 !== 3'd5) begin
      $display("FAIL fault_before: err=%b sel=%0d want err=0 sel=5", err1, sel1); errors++;
    end
    cyc();
    checks++;
    if (err1 !== 1'b1 || err_code1 !== 3'd5) begin
      $display("FAIL fault_first: err=%b code=%0d want 1 5", err1, err_code1); errors++;
    end
    repeat (2) cyc();
    checks++;
    if (st1() !== {3'd7, 1'b0, 1'b1, 1'b1, 3'd5}) begin
      $display("FAIL fault_end: got %b want 111_0_1_1_101", st1()); errors++;
    end
    fault_mask = 8'h00;
    cyc();
  endtask

  task automatic test_single();
    mode = 2'b10; load_val = 3'd6; start3 = 1'b1;
    cyc();
    start3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy3 !== 1'b1 || sel3 !== 3'd6 || done3 !== 1'b0) begin
        $display("FAIL single_busy%0d: busy=%b sel=%0d done=%b want 1 6 0",
                 k, busy3, sel3, done3);
        errors++;
      end
      cyc();
    end
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b1 || sel3 !== 3'd6 || err3 !== 1'b0) begin
      $display("FAIL single_done: busy=%b done=%b sel=%0d err=%b want 0 1 6 0",
               busy3, done3, sel3, err3);
      errors++;
    end
    start3 = 1'b1;  // start in DONE is ignored
    cyc();
    start3 = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0) begin
      $display("FAIL single_idle: busy=%b done=%b want 0 0", busy3, done3); errors++;
    end
    cyc();
    checks++;
    if (busy3 !== 1'b0) begin
      $display("FAIL single_ignore_start: busy=%b want 0", busy3); errors++;
    end
  endtask

  task automatic test_stop();
    mode = 2'b00; load_val = 3'd0; fault_mask = 8'h02; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++;
    if (st1() !== {3'd3, 1'b0, 1'b0, 1'b1, 3'd1}) begin
      $display("FAIL stop_edge: got %b want 011_0_0_1_001", st1()); errors++;
    end
    cyc();
    checks++;
    if (st1() !== {3'd3, 1'b0, 1'b0, 1'b1, 3'd1}) begin
      $display("FAIL stop_hold: got %b want 011_0_0_1_001", st1()); errors++;
    end
    fault_mask = 8'h00; load_val = 3'd4; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    checks++;
    if (st1() !== {3'd4, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      $display("FAIL stop_restart: got %b want 100_1_0_0_000", st1()); errors++;
    end
    repeat (8) cyc();
    checks++;
    if (st1() !== {3'd3, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      $display("FAIL restart_end: got %b want 011_0_1_0_000", st1()); errors++;
    end
    cyc();
  endtask

  task automatic test_async_reset();
    mode = 2'b00; load_val = 3'd0; fault_mask = 8'h01; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (st1() !== 9'd0) begin
      $display("FAIL async_reset: got %b want 000000000", st1()); errors++;
    end
    #1;
    rst = 1'b0;
    fault_mask = 8'h00;
    cyc();
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      $display("FAIL post_reset_idle: busy=%b done=%b want 0 0", busy1, done1); errors++;
    end
    start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    repeat (8) cyc();
    checks++;
    if (st1() !== {3'd7, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      $display("FAIL post_reset_sweep: got %b want 111_0_1_0_000", st1()); errors++;
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_fault();
    test_single();
    test_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
